// File: rtl/divisor_loader.sv
// Divisor operand register: assembles a WIDTH-bit operand from BUS_W-bit beats,
// converts it to sign/magnitude with zero and most-negative flags, and holds it under valid/ready.
module divisor_loader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BUS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] Dbus,
    input  logic [1:0]       Lc,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic             divisor_sign,
    output logic [WIDTH-1:0] curr_divisor,
    output logic             div_zero,
    output logic             min_neg
);

    localparam int unsigned BEATS = WIDTH / BUS_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, CONV, VALID} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   asm_q, asm_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               zero_q, zero_d;
    logic               minneg_q, minneg_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        sign_d   = sign_q;
        div_d    = div_q;
        zero_d   = zero_q;
        minneg_d = minneg_q;

        if (Lc == 2'd1) begin
            state_d  = IDLE;
            cnt_d    = '0;
            asm_d    = '0;
            mode_d   = 1'b0;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            sign_d   = 1'b0;
            div_d    = '0;
            zero_d   = 1'b0;
            minneg_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Lc[1]) begin
                        mode_d = Lc[0];
                        asm_d  = WIDTH'(Dbus);
                        if (BEATS == 1) begin
                            state_d = CONV;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = LOAD;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (Lc[1] && (BEATS > 1)) begin
                        asm_d[int'(cnt_q)*BUS_W +: BUS_W] = Dbus;
                        if (cnt_q == CNT_W'(BEATS - 1)) begin
                            state_d = CONV;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                CONV: begin
                    // Negating the most-negative value wraps to itself, which is its correct magnitude.
                    sign_d   = mode_q & asm_q[WIDTH-1];
                    div_d    = sign_d ? (~asm_q + 1'b1) : asm_q;
                    zero_d   = (asm_q == '0);
                    minneg_d = mode_q && (asm_q == MIN_NEG);
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            asm_q    <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            sign_q   <= 1'b0;
            div_q    <= '0;
            zero_q   <= 1'b0;
            minneg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            sign_q   <= sign_d;
            div_q    <= div_d;
            zero_q   <= zero_d;
            minneg_q <= minneg_d;
        end
    end

    assign busy         = busy_q;
    assign out_valid    = valid_q;
    assign divisor_sign = sign_q;
    assign curr_divisor = div_q;
    assign div_zero     = zero_q;
    assign min_neg      = minneg_q;

endmodule

// File: tb/tb_divisor_loader.sv
// Randomized and directed bench for divisor_loader: default 32/16 instance plus a 16/16 single-beat instance.
module tb_divisor_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, out_ready;
    logic [15:0] Dbus;
    logic [1:0]  Lc;
    logic        busy, out_valid, divisor_sign, div_zero, min_neg;
    logic [31:0] curr_divisor;

    logic        rst2, out_ready2;
    logic [15:0] Dbus2;
    logic [1:0]  Lc2;
    logic        busy2, out_valid2, divisor_sign2, div_zero2, min_neg2;
    logic [15:0] curr_divisor2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] last_mag;
    logic        last_sign, last_zero, last_mn;

    divisor_loader #(.WIDTH(32), .BUS_W(16)) dut (
        .clk(clk), .rst(rst), .Dbus(Dbus), .Lc(Lc), .out_ready(out_ready),
        .busy(busy), .out_valid(out_valid), .divisor_sign(divisor_sign),
        .curr_divisor(curr_divisor), .div_zero(div_zero), .min_neg(min_neg)
    );

    divisor_loader #(.WIDTH(16), .BUS_W(16)) dut16 (
        .clk(clk), .rst(rst2), .Dbus(Dbus2), .Lc(Lc2), .out_ready(out_ready2),
        .busy(busy2), .out_valid(out_valid2), .divisor_sign(divisor_sign2),
        .curr_divisor(curr_divisor2), .div_zero(div_zero2), .min_neg(min_neg2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret the assembled value as a w-bit integer and apply sign/magnitude rules.
    task automatic predict(input int unsigned w, input bit mode, input longint unsigned v,
                           output longint unsigned mag, output bit sgn, output bit zero, output bit mn);
        longint unsigned half, full;
        half = 64'd1 << (w - 1);
        full = 64'd1 << w;
        sgn  = mode && (v >= half);
        mag  = sgn ? (full - v) : v;
        zero = (v == 0);
        mn   = mode && (v == half);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_sign"},  divisor_sign, 0);
        check({tag, "_div"},   curr_divisor, 0);
        check({tag, "_zero"},  div_zero, 0);
        check({tag, "_mn"},    min_neg, 0);
    endtask

    task automatic expect_result(input bit mode, input logic [31:0] val);
        longint unsigned mag;
        bit s, z, m;
        predict(32, mode, longint'(val), mag, s, z, m);
        last_mag  = mag[31:0];
        last_sign = s;
        last_zero = z;
        last_mn   = m;
        check("res_valid", out_valid, 1);
        check("res_busy",  busy, 1);
        check("res_div",   curr_divisor, last_mag);
        check("res_sign",  divisor_sign, last_sign);
        check("res_zero",  div_zero, last_zero);
        check("res_mn",    min_neg, last_mn);
    endtask

    task automatic load_op(input bit mode, input logic [15:0] b0, input logic [15:0] b1,
                           input bit mode2, input int unsigned gap);
        Lc = {1'b1, mode}; Dbus = b0;
        tick();
        Lc = 2'd0;
        check("load_busy",  busy, 0);
        check("load_valid", out_valid, 0);
        for (int unsigned i = 0; i < gap; i++) begin
            Dbus = 16'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        out_ready = 1'b0;
        Lc = {1'b1, mode2}; Dbus = b1;
        tick();
        Lc = 2'd0;
        check("conv_busy",  busy, 1);
        check("conv_valid", out_valid, 0);
        tick();
        expect_result(mode, {b1, b0});
    endtask

    task automatic hold(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            Lc = {1'b1, 1'($urandom)};
            Dbus = 16'($urandom);
            out_ready = 1'b0;
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_busy",  busy, 1);
            check("hold_div",   curr_divisor, last_mag);
            check("hold_sign",  divisor_sign, last_sign);
        end
        Lc = 2'd0;
    endtask

    task automatic consume();
        Lc = ($urandom_range(0, 2) == 0) ? 2'd0 : {1'b1, 1'($urandom)};
        Dbus = 16'($urandom);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        Lc = 2'd0;
        check("cons_valid", out_valid, 0);
        check("cons_busy",  busy, 0);
        check("cons_div",   curr_divisor, last_mag);
        check("cons_sign",  divisor_sign, last_sign);
        check("cons_zero",  div_zero, last_zero);
        check("cons_mn",    min_neg, last_mn);
    endtask

    function automatic logic [15:0] pick_beat();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; Lc = 2'd0; Dbus = '0; out_ready = 1'b0;
        rst2 = 1'b1; Lc2 = 2'd0; Dbus2 = '0; out_ready2 = 1'b0;
        tick();
        tick();
        rst = 1'b0; rst2 = 1'b0;
        check_zero("reset");

        load_op(0, 16'h0007, 16'h0000, 0, 0); consume();
        load_op(1, 16'hFFFA, 16'hFFFF, 1, 0); consume();
        load_op(1, 16'hFFFA, 16'hFFFF, 0, 1); consume();
        load_op(1, 16'h0000, 16'h8000, 1, 0); consume();
        load_op(0, 16'h0000, 16'h0000, 0, 0); consume();
        load_op(0, 16'h0000, 16'h8000, 0, 2); consume();

        // Abort mid-load: a stuck LOAD state would land 0x0005 in the upper half.
        Lc = 2'd2; Dbus = 16'h1234; tick();
        Lc = 2'd1; tick();
        Lc = 2'd0;
        check_zero("abort");
        load_op(0, 16'h0005, 16'h0000, 0, 0); consume();

        Lc = 2'd3; Dbus = 16'hABCD; tick();
        Lc = 2'd0; rst = 1'b1; tick();
        rst = 1'b0;
        check_zero("rst_mid");
        load_op(0, 16'h0009, 16'h0001, 0, 0);
        rst = 1'b1; tick();
        rst = 1'b0;
        check_zero("rst_valid");
        load_op(1, 16'hFFFE, 16'hFFFF, 1, 0);
        Lc = 2'd1; out_ready = 1'b1; tick();
        Lc = 2'd0; out_ready = 1'b0;
        check_zero("clr_valid");

        load_op(0, 16'h1111, 16'h2222, 0, 0);
        hold(5);
        consume();
        load_op(1, 16'h0001, 16'hF000, 1, 0); consume();

        // Single-beat instance.
        Lc2 = 2'd3; Dbus2 = 16'hFFFF; tick();
        Lc2 = 2'd0;
        check("w16_conv_valid", out_valid2, 0);
        check("w16_conv_busy",  busy2, 1);
        tick();
        check("w16_valid", out_valid2, 1);
        check("w16_div",   curr_divisor2, 16'h0001);
        check("w16_sign",  divisor_sign2, 1);
        check("w16_mn",    min_neg2, 0);
        rst2 = 1'b1; tick();
        rst2 = 1'b0;
        check("w16_rst_valid", out_valid2, 0);
        check("w16_rst_busy",  busy2, 0);
        check("w16_rst_div",   curr_divisor2, 0);
        check("w16_rst_sign",  divisor_sign2, 0);
        Lc2 = 2'd3; Dbus2 = 16'h8000; tick();
        Lc2 = 2'd0; tick();
        check("w16_mn_div",  curr_divisor2, 16'h8000);
        check("w16_mn_flag", min_neg2, 1);
        check("w16_mn_sign", divisor_sign2, 1);
        out_ready2 = 1'b1; tick();
        out_ready2 = 1'b0;
        check("w16_cons_valid", out_valid2, 0);
        check("w16_cons_div",   curr_divisor2, 16'h8000);

        for (int unsigned it = 0; it < 40; it++) begin
            logic [15:0] b0, b1;
            bit m;
            m  = 1'($urandom);
            b0 = pick_beat();
            b1 = pick_beat();
            load_op(m, b0, b1, 1'($urandom), $urandom_range(0, 2));
            hold($urandom_range(0, 3));
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divisor_loader.md
Name: divisor_loader

Overview:
- Parametrised successor to the divider's divisor operand register.
- Assembles a WIDTH-bit divisor from a narrower data bus over several beats, in signed or unsigned mode.
- Registers sign and magnitude, flags divide-by-zero and the most-negative value, then presents the result to the subtract/compare datapath.
- A valid/ready handshake on the output holds the operand until the datapath consumes it.

Parameters:
- WIDTH, 32, divisor width in bits; must be an integer multiple of BUS_W.
- BUS_W, 16, data bus width in bits; BEATS = WIDTH/BUS_W (local, at least 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Dbus  input  BUS_W  data bus; carries one operand slice per beat.
- Lc  input  2  load code from the control unit: 0 hold, 1 clear/abort, 2 load beat unsigned, 3 load beat signed.
- out_ready  input  1  datapath accepts the presented divisor.
- busy  output  1  high in CONV and VALID; load beats are ignored while high.
- out_valid  output  1  curr_divisor, divisor_sign and the flags are valid.
- divisor_sign  output  1  operand was negative (signed mode only).
- curr_divisor  output  WIDTH  magnitude of the operand.
- div_zero  output  1  operand equals 0.
- min_neg  output  1  signed mode and operand equals 1 followed by WIDTH-1 zeros.

Behaviour:
- Reset (rst high at an edge): state IDLE, beat counter 0, assembly register 0. All outputs 0: busy, out_valid, divisor_sign, curr_divisor, div_zero, min_neg.
- Reset has priority over every other input and is legal in any state, including mid-load and VALID.
- Lc==1 (clear) at an edge returns to IDLE and clears outputs, counter and assembly register exactly as reset does. Clear has priority over loads and over out_ready.
- States: IDLE, LOAD, CONV, VALID.
- IDLE:
  - Lc[1]==1 accepts beat 0 and latches mode = Lc[0].
  - Dbus goes to assembly bits [BUS_W-1:0] (little-endian beat order).
  - If BEATS==1, go to CONV; otherwise go to LOAD with counter=1.
- LOAD:
  - Each cycle with Lc[1]==1 accepts beat k = counter into bits [(k+1)*BUS_W-1 : k*BUS_W], then increments the counter.
  - Lc[0] on beats after beat 0 is ignored; mode stays as latched.
  - Lc==0 holds the state with no timeout.
  - After beat BEATS-1 is accepted, go to CONV.
- CONV (exactly one cycle); at the exiting edge, register:
  - signed mode with MSB=1: divisor_sign=1, curr_divisor = two's-complement negation (modulo 2^WIDTH).
  - otherwise: divisor_sign=0, curr_divisor = assembled value.
  - div_zero = (assembled == 0).
  - min_neg = signed mode and assembled == 2^(WIDTH-1); curr_divisor is then 2^(WIDTH-1) as an unsigned magnitude.
  - out_valid=1; go to VALID.
- Latency: last beat sampled at edge E; out_valid and outputs update at edge E+1.
- VALID:
  - Outputs stay stable while out_ready==0. Load beats are ignored, with no side effects on the counter or assembly register.
  - out_ready==1 at an edge: out_valid goes to 0 and state goes to IDLE. curr_divisor, divisor_sign and the flags hold their values. A load beat in that same cycle is ignored.
- busy is a registered output reflecting the state: 1 in CONV and VALID, 0 in IDLE and LOAD.
- out_ready is ignored outside VALID.

Test Plan:
- Unsigned, defaults: Lc=2 with Dbus=0x0007, then Lc=2 with Dbus=0x0000 -> one edge later curr_divisor=0x00000007, divisor_sign=0, div_zero=0, out_valid=1.
- Signed: Lc=3 with 0xFFFA, then 0xFFFF -> curr_divisor=0x00000006, divisor_sign=1, min_neg=0. Repeat with the second beat on Lc=2 -> same result (mode stays latched).
- Signed most-negative: beats 0x0000, 0x8000 on Lc=3 -> curr_divisor=0x80000000, divisor_sign=1, min_neg=1. Unsigned zero: beats 0x0000, 0x0000 -> div_zero=1, divisor_sign=0.
- Abort: beat 0x1234 on Lc=2, then Lc=1, then beats 0x0005, 0x0000 -> curr_divisor=0x00000005, no residue from 0x1234. Separately, rst after beat 0 -> all outputs 0, state IDLE.
- Backpressure: after a result, hold out_ready=0 for 5 cycles while driving Lc=3/0xFFFF -> outputs unchanged, busy=1. Then out_ready=1 -> out_valid=0 next edge, and a new load is then accepted.
- Parameter sweep WIDTH=16, BUS_W=16: single beat 0xFFFF on Lc=3 -> curr_divisor=0x0001, divisor_sign=1, with out_valid 1 edge after the beat. rst during VALID -> all outputs 0 at the next edge.
